psum_accumulator: RTL and testbench

Accumulates per-pixel 3×3 dot products from the convolver MAC stage across all input channels of a layer. Holds running partial sums in an internal buffer indexed by output pixel. On the last channel it adds the per-filter bias, applies optional ReLU and saturates to line width. The result goes to the output feature-map writer.

---
 rtl/psum_accumulator.sv | 187 ++++++++++++++++++
 tb/tb_psum_accumulator.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: folds per-pixel MAC results across all input channels and emits biased, saturated pixels.
// Optional PSUM_RELU_EN clamps negative final sums to zero before saturation.
module psum_accumulator #(
  parameter int IN_W  = 32,
  parameter int ACC_W = 40,
  parameter int OUT_W = 16,
  parameter int DEPTH = 1024,
  parameter int PIX_W = 10,
  parameter int CH_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PIX_W:0]   num_pixels,
  input  logic [CH_W-1:0]  num_channels,
  input  logic [OUT_W-1:0] bias,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [PIX_W-1:0] out_pix,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // Handshake: in_valid is a one-way strobe with no ready; every beat seen in
  // RUN is consumed. out_valid is likewise a one-cycle strobe the consumer must take.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  state_t             state_q;
  logic [PIX_W:0]     np_q;
  logic [CH_W-1:0]    nc_q;
  logic [ACC_W-1:0]   bias_q;
  logic [PIX_W-1:0]   pix_cnt_q;
  logic [CH_W-1:0]    ch_cnt_q;

  logic               s1_valid_q;
  logic [ACC_W-1:0]   s1_data_q;
  logic [PIX_W-1:0]   s1_pix_q;
  logic               s1_first_q;
  logic               s1_last_q;
  logic [ACC_W-1:0]   rd_q;

  logic               s2_valid_q;
  logic               s2_last_q;
  logic [ACC_W-1:0]   s2_sum_q;
  logic [PIX_W-1:0]   s2_pix_q;

  logic               out_valid_q;
  logic [OUT_W-1:0]   out_data_q;
  logic [PIX_W-1:0]   out_pix_q;
  logic               busy_q;
  logic               done_q;

  logic [ACC_W-1:0]   mem [DEPTH];

  logic               accept;
  logic               last_pix;
  logic               last_ch;
  logic [ACC_W-1:0]   in_ext;
  logic [ACC_W-1:0]   sum_d;
  logic               wr_en;
  logic signed [ACC_W-1:0] post;
  logic [OUT_W-1:0]   out_sat;

  assign accept   = (state_q == S_RUN) && in_valid;
  assign last_pix = ({1'b0, pix_cnt_q} == (np_q - 1'b1));
  assign last_ch  = (ch_cnt_q == (nc_q - 1'b1));
  assign in_ext   = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign wr_en    = s1_valid_q && !s1_last_q;

  // A first-channel beat ignores whatever stale value the buffer holds.
  assign sum_d = (s1_first_q ? '0 : rd_q) + s1_data_q + (s1_last_q ? bias_q : '0);

  always_comb begin
    post = s2_sum_q;
`ifdef PSUM_RELU_EN
    if (post[ACC_W-1]) post = '0;
`endif
    if (post > SAT_MAX)      out_sat = {1'b0, {(OUT_W-1){1'b1}}};
    else if (post < SAT_MIN) out_sat = {1'b1, {(OUT_W-1){1'b0}}};
    else                     out_sat = post[OUT_W-1:0];
  end

  // Buffer and its read register carry no reset; channel 0 overwrites every entry.
  // With a single pixel the read can collide with the write in flight, so bypass it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[s1_pix_q] <= sum_d;
    if (accept) rd_q <= (wr_en && (s1_pix_q == pix_cnt_q)) ? sum_d : mem[pix_cnt_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      np_q        <= '0;
      nc_q        <= '0;
      bias_q      <= '0;
      pix_cnt_q   <= '0;
      ch_cnt_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_pix_q    <= '0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_sum_q    <= '0;
      s2_pix_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_pix_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      s1_valid_q <= accept;
      if (accept) begin
        s1_data_q  <= in_ext;
        s1_pix_q   <= pix_cnt_q;
        s1_first_q <= (ch_cnt_q == '0);
        s1_last_q  <= last_ch;
      end

      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_sum_q   <= sum_d;
      s2_pix_q   <= s1_pix_q;

      out_valid_q <= s2_valid_q && s2_last_q;
      if (s2_valid_q && s2_last_q) begin
        out_data_q <= out_sat;
        out_pix_q  <= s2_pix_q;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            np_q      <= num_pixels;
            nc_q      <= num_channels;
            bias_q    <= {{(ACC_W-OUT_W){bias[OUT_W-1]}}, bias};
            pix_cnt_q <= '0;
            ch_cnt_q  <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          if (in_valid) begin
            if (last_pix) begin
              pix_cnt_q <= '0;
              ch_cnt_q  <= ch_cnt_q + 1'b1;
              if (last_ch) state_q <= S_FLUSH;
            end else begin
              pix_cnt_q <= pix_cnt_q + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          // Final beat has left stage 1; its output registers on this same edge.
          if (!s1_valid_q) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_pix   = out_pix_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: directed layer passes plus randomized passes scored against a per-pixel channel-sum model.
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] num_pixels = '0;
  logic [9:0]  num_channels = '0;
  logic [15:0] bias = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [9:0]  out_pix;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  psum_accumulator dut (
    .clk(clk), .rst(rst), .start(start),
    .num_pixels(num_pixels), .num_channels(num_channels), .bias(bias),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_pix(out_pix),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int d_last = 0;

  // scoreboard entry: {expected cycle[31:0], pixel[9:0], data[15:0]}
  logic [57:0] exp_q[$];
  logic signed [31:0] din[$];
  logic [15:0] exp_px [1024];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    logic [57:0] e;
    if (out_valid) begin
      check("out_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_cycle", 64'(cyc), 64'(e[57:26]));
        check("out_pix", 64'(out_pix), 64'(e[25:16]));
        check("out_data", 64'(out_data), 64'(e[15:0]));
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("busy_at_done", 64'(busy), 64'd0);
    end
  end

  // reference model: per pixel, sum every channel's beat plus bias, then clamp
  function automatic logic [15:0] clamp(input logic signed [39:0] s);
    logic signed [39:0] v;
    v = s;
`ifdef PSUM_RELU_EN
    if (v < 0) v = 0;
`endif
    if (v > 40'sd32767) return 16'h7fff;
    if (v < -40'sd32768) return 16'h8000;
    return v[15:0];
  endfunction

  task automatic model_pass(input int np, input int nc, input logic signed [15:0] b);
    logic signed [39:0] s;
    for (int p = 0; p < np; p++) begin
      s = 0;
      for (int c = 0; c < nc; c++) s = s + din[c * np + p];
      s = s + b;
      exp_px[p] = clamp(s);
    end
  endtask

  // driver tasks
  task automatic start_pass(input int np, input int nc, input logic [15:0] b);
    @(negedge clk);
    start = 1'b1;
    num_pixels = 11'(np);
    num_channels = 10'(nc);
    bias = b;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic drive_beats(input int np, input int nc, input int count, input bit gaps, input bit poke);
    for (int i = 0; i < count; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      start = poke && (i == 1);
      if (start) begin
        num_pixels = 11'($urandom_range(1, 4));
        num_channels = 10'($urandom_range(1, 4));
        bias = 16'($urandom);
      end
      in_valid = 1'b1;
      in_data = din[i];
      d_last = cyc;
      if (i / np == nc - 1) exp_q.push_back({32'(cyc + 3), 10'(i % np), exp_px[i % np]});
      @(negedge clk);
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done(input int t0);
    for (int k = 0; k < 20 && done_cnt == t0; k++) @(negedge clk);
    check("done_count", 64'(done_cnt - t0), 64'd1);
    check("done_cycle", 64'(done_cyc), 64'(d_last + 3));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("state_idle", 64'(dbg_state), 64'd0);
  endtask

  task automatic run_pass(input int np, input int nc, input logic [15:0] b, input bit gaps, input bit poke);
    int t0;
    model_pass(np, nc, b);
    start_pass(np, nc, b);
    t0 = done_cnt;
    drive_beats(np, nc, np * nc, gaps, poke);
    wait_done(t0);
  endtask

  task automatic fill(input int n, input logic signed [31:0] v);
    din.delete();
    for (int i = 0; i < n; i++) din.push_back(v);
  endtask

  initial begin
    int np, nc, t0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_pix", 64'(out_pix), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);

    // single channel with bias, mixed signs
    din.delete();
    din.push_back(32'sd10); din.push_back(-32'sd20); din.push_back(32'sd3); din.push_back(32'sd0);
    run_pass(4, 1, 16'd5, 1'b0, 1'b0);

    // three channels, output only during the last
    fill(9, 32'sd7);
    run_pass(3, 3, 16'd0, 1'b0, 1'b0);

    // single pixel back-to-back exercises the read bypass
    fill(4, 32'sd100);
    run_pass(1, 4, 16'd1, 1'b0, 1'b0);

    // saturation both ways
    fill(2, 32'sd30000);
    run_pass(1, 2, 16'd0, 1'b0, 1'b0);
    fill(2, -32'sd30000);
    run_pass(1, 2, 16'd0, 1'b0, 1'b0);

    // abort mid-pass in channel 2, then a clean pass must not see stale sums
    fill(9, 32'sd7);
    model_pass(3, 3, 16'd0);
    start_pass(3, 3, 16'd0);
    drive_beats(3, 3, 4, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    t0 = done_cnt;
    repeat (6) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - t0), 64'd0);
    din.delete();
    din.push_back(32'sd1); din.push_back(32'sd2);
    run_pass(2, 1, 16'd0, 1'b0, 1'b0);

    // in_valid while idle must do nothing
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_state", 64'(dbg_state), 64'd0);
    repeat (4) @(negedge clk);

    // start pulsed mid-pass must be ignored
    fill(12, 32'sd9);
    run_pass(4, 3, 16'hfff0, 1'b0, 1'b1);

    // randomized passes
    for (int r = 0; r < 25; r++) begin
      np = $urandom_range(1, 8);
      nc = $urandom_range(1, 4);
      din.delete();
      for (int i = 0; i < np * nc; i++) begin
        if ($urandom_range(0, 3) == 0) din.push_back(32'($urandom));
        else din.push_back(32'(int'($urandom_range(0, 40000)) - 20000));
      end
      run_pass(np, nc, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
